// File: rtl/matmul_pkg.sv
// Shared configuration for the matrix-multiply stream controller and its multiplier:
// sizes, controller state encoding and the padded flat element index.
package matmul_pkg;

  localparam int MAX_SIZE   = 10;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_ELEMS  = MAX_SIZE * MAX_SIZE;
  localparam int FLAT_W     = NUM_ELEMS * DATA_WIDTH;
  localparam int CW         = $clog2(MAX_SIZE) + 1;
  localparam int ADDR_W     = $clog2(NUM_ELEMS);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DRAIN} state_t;

  typedef logic [DATA_WIDTH-1:0] elem_t;

  // Rows are always MAX_SIZE wide so the padding lines up with the multiplier layout.
  function automatic logic [ADDR_W-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(MAX_SIZE) + ADDR_W'(c);
  endfunction

endpackage

// File: rtl/matmul_rc_counter.sv
// Row/column walker over an n x n matrix: column wraps at n-1 into the next row,
// the whole counter wraps to (0,0) after the last element.
module matmul_rc_counter
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic [CW-1:0] n,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic col_end;

  assign col_end = (col == n - CW'(1));
  assign last    = col_end && (row == n - CW'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/matmul_stream_ctrl.sv
// Sequencer in front of the flat matrix multiplier: loads A and B from a valid/ready
// stream, pulses the multiplier enable, captures C and streams it back out row-major.
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int MM_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           cfg_size,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  size_err,
  output logic                  mm_enable,
  output logic [31:0]           mm_size,
  output logic [FLAT_W-1:0]     mm_A,
  output logic [FLAT_W-1:0]     mm_B,
  input  logic [FLAT_W-1:0]     mm_C,
  input  logic                  mm_done
);

  localparam int RUN_W = $clog2(MM_CYCLES + 1);

  state_t           state, state_next;
  logic [RUN_W-1:0] run_cnt;
  logic [CW-1:0]    n;
  logic [CW-1:0]    load_row, load_col, drain_row, drain_col;
  logic             load_last, drain_last;
  logic             size_ok, start_ok, in_fire, out_fire, run_done, in_idle;

  elem_t a_mem [NUM_ELEMS];
  elem_t b_mem [NUM_ELEMS];
  elem_t c_mem [NUM_ELEMS];
  elem_t c_in  [NUM_ELEMS];

  assign n         = mm_size[CW-1:0];
  assign in_idle   = (state == IDLE);
  assign size_ok   = (cfg_size != '0) && (cfg_size <= 32'(MAX_SIZE));
  assign start_ok  = in_idle && start && size_ok;
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign busy      = !in_idle;
  assign mm_enable = (state == RUN) && (run_cnt < RUN_W'(MM_CYCLES));
  assign run_done  = (state == RUN) && (run_cnt == RUN_W'(MM_CYCLES));
  assign out_data  = c_mem[idx(drain_row, drain_col)];
  assign out_last  = out_valid && drain_last;

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_flat
    assign mm_A[g*DATA_WIDTH +: DATA_WIDTH] = a_mem[g];
    assign mm_B[g*DATA_WIDTH +: DATA_WIDTH] = b_mem[g];
    assign c_in[g] = mm_C[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // One walker is shared by A and B: it wraps to (0,0) on the last A element.
  matmul_rc_counter u_load_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_idle),
    .advance (in_fire),
    .n       (n),
    .row     (load_row),
    .col     (load_col),
    .last    (load_last)
  );

  matmul_rc_counter u_drain_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_idle),
    .advance (out_fire),
    .n       (n),
    .row     (drain_row),
    .col     (drain_col),
    .last    (drain_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mm_size  <= '0;
      size_err <= 1'b0;
      run_cnt  <= '0;
    end else begin
      state    <= state_next;
      size_err <= in_idle && start && !size_ok;
      run_cnt  <= ((state == RUN) && !run_done) ? run_cnt + RUN_W'(1) : '0;
      if (start_ok) begin
        mm_size <= cfg_size;
      end
    end
  end

  // Buffers survive reset; a new job zeroes them so a smaller n never sees stale padding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (start_ok) begin
        a_mem <= '{default: '0};
        b_mem <= '{default: '0};
        c_mem <= '{default: '0};
      end
      if ((state == LOAD_A) && in_fire) begin
        a_mem[idx(load_row, load_col)] <= in_data;
      end
      if ((state == LOAD_B) && in_fire) begin
        b_mem[idx(load_row, load_col)] <= in_data;
      end
      if (run_done) begin
        c_mem <= c_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok)               state_next = LOAD_A;
      LOAD_A:  if (in_fire && load_last)   state_next = LOAD_B;
      LOAD_B:  if (in_fire && load_last)   state_next = RUN;
      RUN:     if (run_done)               state_next = DRAIN;
      DRAIN:   if (out_fire && drain_last) state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // C is captured regardless; a missing done only flags a multiplier timing problem.
  mm_done_at_capture: assert property (@(posedge clk) disable iff (rst) run_done |-> mm_done);

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Self-checking bench for matmul_stream_ctrl: a behavioural multiplier stub plus a
// queue-based model of the expected C stream, driven with random stalls and data.
module tb_matmul_stream_ctrl;
  import matmul_pkg::*;

  localparam int MM = 2;

  logic                  clk = 1'b0;
  logic                  rst, start, in_valid, out_ready, mm_done;
  logic                  in_ready, out_valid, out_last, busy, size_err, mm_enable;
  logic [31:0]           cfg_size, mm_size;
  logic [DATA_WIDTH-1:0] in_data, out_data;
  logic [FLAT_W-1:0]     mm_A, mm_B, mm_C;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_latency = 0;
  bit watch_latency = 0;
  int out_mode = 0;

  logic [31:0] host_a [NUM_ELEMS];
  logic [31:0] host_b [NUM_ELEMS];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  elem_t a_el [NUM_ELEMS];
  elem_t b_el [NUM_ELEMS];
  elem_t c_el [NUM_ELEMS];

  matmul_stream_ctrl #(.MM_CYCLES(MM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_size  (cfg_size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .size_err  (size_err),
    .mm_enable (mm_enable),
    .mm_size   (mm_size),
    .mm_A      (mm_A),
    .mm_B      (mm_B),
    .mm_C      (mm_C),
    .mm_done   (mm_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_stub
    assign a_el[g] = mm_A[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_el[g] = mm_B[g*DATA_WIDTH +: DATA_WIDTH];
    assign mm_C[g*DATA_WIDTH +: DATA_WIDTH] = c_el[g];
  end

  // Multiplier stand-in: full MAX_SIZE product over the padded flat buffers.
  initial begin
    mm_done = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) c_el[i] = '0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        mm_done = 1'b0;
      end else if (mm_enable) begin
        for (int r = 0; r < MAX_SIZE; r++) begin
          for (int c = 0; c < MAX_SIZE; c++) begin
            logic [31:0] s;
            s = '0;
            for (int k = 0; k < MAX_SIZE; k++) s += a_el[r*MAX_SIZE+k] * b_el[k*MAX_SIZE+c];
            c_el[r*MAX_SIZE+c] = s;
          end
        end
        mm_done = 1'b1;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected C in row-major order from dense host matrices.
  task automatic buildExpected(input int n);
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < n; k++) s += host_a[r*n+k] * host_b[k*n+c];
        exp_q.push_back(s);
      end
    end
  endtask

  // Compare process: every accepted output against the model, plus stall stability.
  initial begin
    bit    prev_stall;
    elem_t prev_data;
    logic  prev_last;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (out_valid) begin
          if (watch_latency) begin
            checkOutput("latency", 64'(cyc - start_cyc), 64'(exp_latency));
            watch_latency = 0;
          end
          if (prev_stall) begin
            checkOutput("stall_data", out_data, prev_data);
            checkOutput("stall_last", out_last, prev_last);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checkOutput("extra_output", 64'(exp_q.size()), 64'd1);
            end else begin
              checkOutput("out_data", out_data, exp_q[0]);
              checkOutput("out_last", out_last, exp_q.size() == 1);
              got_q.push_back(out_data);
              void'(exp_q.pop_front());
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Start a job of size n and feed n_feed elements (A then B), optionally with bubbles.
  task automatic applyStimulus(input int n, input bit stall_in, input int n_feed);
    int  i;
    int  t;
    bit  hs;
    @(posedge clk);
    #1;
    start    = 1'b1;
    cfg_size = 32'(n);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    i = 0;
    t = 0;
    while (i < n_feed && t < 5000) begin
      in_valid = stall_in ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = (i < n*n) ? host_a[i] : host_b[i-n*n];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      t++;
    end
    in_valid = 1'b0;
    if (i < n_feed) checkOutput("feed_timeout", 64'(i), 64'(n_feed));
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_out_valid", out_valid, 1'b0);
  endtask

  task automatic runCase(input int n, input bit stall_in, input int mode, input bit lat);
    out_mode = mode;
    buildExpected(n);
    got_q.delete();
    exp_latency   = 2*n*n + MM + 2;
    watch_latency = lat;
    applyStimulus(n, stall_in, 2*n*n);
    checkOutput("mm_size", mm_size, 64'(n));
    waitDrain();
  endtask

  task automatic checkResetState();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_size_err", size_err, 1'b0);
    checkOutput("rst_mm_enable", mm_enable, 1'b0);
    checkOutput("rst_mm_size", mm_size, 64'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t;
    logic [31:0] bad_sizes [2];
    rst      = 1'b1;
    start    = 1'b0;
    cfg_size = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] n=2 literal product, no stalls");
    host_a[0] = 1; host_a[1] = 2; host_a[2] = 3; host_a[3] = 4;
    host_b[0] = 5; host_b[1] = 6; host_b[2] = 7; host_b[3] = 8;
    buildExpected(2);
    checkOutput("model_c00", exp_q[0], 64'd19);
    checkOutput("model_c01", exp_q[1], 64'd22);
    checkOutput("model_c10", exp_q[2], 64'd43);
    checkOutput("model_c11", exp_q[3], 64'd50);
    runCase(2, 0, 0, 1);
    checkOutput("lit_latency", 64'(exp_latency), 64'd12);
    checkOutput("lit_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      checkOutput("lit_c00", got_q[0], 64'd19);
      checkOutput("lit_c11", got_q[3], 64'd50);
    end

    $display("[TB] n=1 after n=2, stale padding must be zeroed");
    host_a[0] = 7;
    host_b[0] = 6;
    runCase(1, 0, 0, 1);
    checkOutput("n1_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) checkOutput("n1_value", got_q[0], 64'd42);

    $display("[TB] n=3 identity times 1..9 with stalls");
    for (int i = 0; i < 9; i++) begin
      host_a[i] = (i % 4 == 0) ? 32'd1 : 32'd0;
      host_b[i] = 32'(i + 1);
    end
    runCase(3, 1, 1, 0);
    checkOutput("n3_count", 64'(got_q.size()), 64'd9);
    if (got_q.size() == 9) begin
      for (int i = 0; i < 9; i++) checkOutput("n3_value", got_q[i], 64'(i + 1));
    end

    $display("[TB] n=10 all ones");
    for (int i = 0; i < NUM_ELEMS; i++) begin
      host_a[i] = 1;
      host_b[i] = 1;
    end
    runCase(MAX_SIZE, 0, 0, 1);
    checkOutput("n10_latency", 64'(exp_latency), 64'd204);
    checkOutput("n10_count", 64'(got_q.size()), 64'd100);
    if (got_q.size() == 100) checkOutput("n10_last_value", got_q[99], 64'd10);

    $display("[TB] bad sizes");
    bad_sizes[0] = 32'd0;
    bad_sizes[1] = 32'd11;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      start    = 1'b1;
      cfg_size = bad_sizes[i];
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("size_err_pulse", size_err, 1'b1);
      checkOutput("size_err_busy", busy, 1'b0);
      checkOutput("size_err_in_ready", in_ready, 1'b0);
      @(negedge clk);
      checkOutput("size_err_clear", size_err, 1'b0);
      checkOutput("size_err_idle", busy, 1'b0);
    end

    $display("[TB] reset during LOAD_B");
    out_mode = 0;
    exp_q.delete();
    watch_latency = 0;
    for (int i = 0; i < 9; i++) begin
      host_a[i] = $urandom;
      host_b[i] = $urandom;
    end
    applyStimulus(3, 1, 11);
    checkOutput("loadb_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset during DRAIN");
    for (int i = 0; i < 4; i++) begin
      host_a[i] = $urandom;
      host_b[i] = $urandom;
    end
    out_mode = 2;
    buildExpected(2);
    applyStimulus(2, 0, 8);
    t = 0;
    while (!out_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_reached", out_valid, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetState();
    exp_q.delete();
    out_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] random jobs");
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, MAX_SIZE);
      for (int i = 0; i < n*n; i++) begin
        host_a[i] = $urandom;
        host_b[i] = $urandom;
      end
      runCase(n, 1'($urandom_range(0, 1)), 1, 0);
      checkOutput("rand_count", 64'(got_q.size()), 64'(n*n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
